// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer: decodes JEDEC-style unlock/command bus writes into program/erase strobes.
// Optional build macro TIMEOUT_EN aborts a partial sequence after TIMEOUT_CYCLES idle clocks.
module flash_cmd_sequencer #(
   parameter int          ADDR_W         = 16,
   parameter int          DATA_W         = 8,
   parameter int unsigned UNLOCK_ADDR1   = 'h5555,
   parameter int unsigned UNLOCK_ADDR2   = 'hAAAA,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              EN,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   output logic              readEnable,
   output logic              writeEnable,
   output logic              eraseEnable,
   output logic              erase_all,
   output logic [ADDR_W-1:0] op_addr,
   output logic [DATA_W-1:0] op_data,
   output logic              busy,
   output logic              seq_error
);

   // state  | meaning
   // IDLE   | read mode, waiting for first unlock (A1,AA)
   // U1     | first unlock seen, expecting (A2,55)
   // U2     | unlocked, expecting command byte at A1
   // PROG   | next write is the program address/data
   // E_U0   | erase setup seen, expecting (A1,AA)
   // E_U1   | expecting (A2,55)
   // E_U2   | expecting chip (A1,10) or sector (any,30) erase
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_U1   = 3'd1;
   localparam logic [2:0] S_U2   = 3'd2;
   localparam logic [2:0] S_PROG = 3'd3;
   localparam logic [2:0] S_E_U0 = 3'd4;
   localparam logic [2:0] S_E_U1 = 3'd5;
   localparam logic [2:0] S_E_U2 = 3'd6;

   localparam logic [ADDR_W-1:0] A1 = ADDR_W'(UNLOCK_ADDR1);
   localparam logic [ADDR_W-1:0] A2 = ADDR_W'(UNLOCK_ADDR2);

   localparam logic [DATA_W-1:0] D_AA = DATA_W'(8'hAA);
   localparam logic [DATA_W-1:0] D_55 = DATA_W'(8'h55);
   localparam logic [DATA_W-1:0] D_00 = DATA_W'(8'h00);
   localparam logic [DATA_W-1:0] D_20 = DATA_W'(8'h20);
   localparam logic [DATA_W-1:0] D_80 = DATA_W'(8'h80);
   localparam logic [DATA_W-1:0] D_10 = DATA_W'(8'h10);
   localparam logic [DATA_W-1:0] D_30 = DATA_W'(8'h30);
   localparam logic [DATA_W-1:0] D_F0 = DATA_W'(8'hF0);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic              wr_nxt;
   logic              er_nxt;
   logic              all_nxt;
   logic              err_nxt;
   logic              mismatch;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              is_a1;
   logic              hit_a1_aa;
   logic              hit_a2_55;
   logic              tmo_hit;

   assign is_a1     = (address == A1);
   assign hit_a1_aa = is_a1 && (data == D_AA);
   assign hit_a2_55 = (address == A2) && (data == D_55);

`ifdef TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   // Counter holds the number of idle clocks since the last write of this sequence.
   assign tmo_hit = (state != S_IDLE) && !EN && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if (EN || (state == S_IDLE) || tmo_hit) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      wr_nxt    = 1'b0;
      er_nxt    = 1'b0;
      all_nxt   = erase_all;
      err_nxt   = 1'b0;
      mismatch  = 1'b0;
      addr_nxt  = op_addr;
      data_nxt  = op_data;
      if (EN) begin
         // 0xF0 is a soft reset from anywhere and outranks every other decode.
         if (data == D_F0) begin
            state_nxt = S_IDLE;
         end else begin
            case (state)
               S_IDLE: if (hit_a1_aa) state_nxt = S_U1;
               S_U1: begin
                  if (hit_a2_55) state_nxt = S_U2;
                  else           mismatch  = 1'b1;
               end
               S_U2: begin
                  if      (is_a1 && data == D_00) state_nxt = S_IDLE;
                  else if (is_a1 && data == D_20) state_nxt = S_PROG;
                  else if (is_a1 && data == D_80) state_nxt = S_E_U0;
                  else                            mismatch  = 1'b1;
               end
               S_PROG: begin
                  wr_nxt    = 1'b1;
                  addr_nxt  = address;
                  data_nxt  = data;
                  state_nxt = S_IDLE;
               end
               S_E_U0: begin
                  if (hit_a1_aa) state_nxt = S_E_U1;
                  else           mismatch  = 1'b1;
               end
               S_E_U1: begin
                  if (hit_a2_55) state_nxt = S_E_U2;
                  else           mismatch  = 1'b1;
               end
               S_E_U2: begin
                  if (is_a1 && data == D_10) begin
                     er_nxt    = 1'b1;
                     all_nxt   = 1'b1;
                     addr_nxt  = A1;
                     state_nxt = S_IDLE;
                  end else if (data == D_30) begin
                     er_nxt    = 1'b1;
                     all_nxt   = 1'b0;
                     addr_nxt  = address;
                     state_nxt = S_IDLE;
                  end else begin
                     mismatch = 1'b1;
                  end
               end
               default: state_nxt = S_IDLE;
            endcase
            // A stray first-unlock write restarts the sequence instead of being lost.
            if (mismatch) begin
               err_nxt   = 1'b1;
               state_nxt = hit_a1_aa ? S_U1 : S_IDLE;
            end
         end
      end else if (tmo_hit) begin
         err_nxt   = 1'b1;
         state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         readEnable  <= 1'b1;
         busy        <= 1'b0;
         writeEnable <= 1'b0;
         eraseEnable <= 1'b0;
         erase_all   <= 1'b0;
         seq_error   <= 1'b0;
         op_addr     <= '0;
         op_data     <= '0;
      end else begin
         state       <= state_nxt;
         readEnable  <= (state_nxt == S_IDLE);
         busy        <= (state_nxt != S_IDLE);
         writeEnable <= wr_nxt;
         eraseEnable <= er_nxt;
         erase_all   <= all_nxt;
         seq_error   <= err_nxt;
         op_addr     <= addr_nxt;
         op_data     <= data_nxt;
      end
   end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb_flash_cmd_sequencer: directed and randomized checks of flash_cmd_sequencer against a
// pattern-matching model of the command sequences.
module tb_flash_cmd_sequencer;
   localparam int AW  = 16;
   localparam int DW  = 8;
   localparam int TMO = 8;
   localparam logic [15:0] A1 = 16'h5555;
   localparam logic [15:0] A2 = 16'hAAAA;

   logic          clk = 1'b0;
   logic          reset;
   logic          EN;
   logic [AW-1:0] address;
   logic [DW-1:0] data;
   logic          readEnable, writeEnable, eraseEnable, erase_all, busy, seq_error;
   logic [AW-1:0] op_addr;
   logic [DW-1:0] op_data;

   flash_cmd_sequencer #(
      .ADDR_W(AW), .DATA_W(DW), .UNLOCK_ADDR1('h5555), .UNLOCK_ADDR2('hAAAA),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .EN(EN), .address(address), .data(data),
      .readEnable(readEnable), .writeEnable(writeEnable), .eraseEnable(eraseEnable),
      .erase_all(erase_all), .op_addr(op_addr), .op_data(op_data), .busy(busy),
      .seq_error(seq_error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   // Model: the writes accepted so far in the current sequence, matched against command templates.
   wr_t         hist[$];
   logic        m_wr, m_er, m_all, m_err;
   logic [15:0] m_addr;
   logic [7:0]  m_data;
`ifdef TIMEOUT_EN
   int          idle_cnt;
`endif

   wr_t pat[4][6];
   bit  any_a[4][6];
   bit  any_d[4][6];
   int  plen[4];

   function automatic wr_t mk(input logic [15:0] a, input logic [7:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      return w;
   endfunction

   task automatic init_patterns();
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 6; i++) begin
            pat[p][i] = mk(A1, 8'h00); any_a[p][i] = 0; any_d[p][i] = 0;
         end
         pat[p][0] = mk(A1, 8'hAA);
         pat[p][1] = mk(A2, 8'h55);
      end
      // 0 read-reset, 1 program, 2 chip erase, 3 sector erase
      plen[0] = 3; pat[0][2] = mk(A1, 8'h00);
      plen[1] = 4; pat[1][2] = mk(A1, 8'h20); any_a[1][3] = 1; any_d[1][3] = 1;
      for (int p = 2; p < 4; p++) begin
         plen[p] = 6;
         pat[p][2] = mk(A1, 8'h80);
         pat[p][3] = mk(A1, 8'hAA);
         pat[p][4] = mk(A2, 8'h55);
      end
      pat[2][5] = mk(A1, 8'h10);
      pat[3][5] = mk(A1, 8'h30); any_a[3][5] = 1;
   endtask

   function automatic int match_pat(input int p, input wr_t c[$]);
      if (c.size() > plen[p]) return 0;
      foreach (c[i]) begin
         if (!((any_a[p][i] || c[i].a == pat[p][i].a) && (any_d[p][i] || c[i].d == pat[p][i].d)))
            return 0;
      end
      return (c.size() == plen[p]) ? 2 : 1;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_wr = 0; m_er = 0; m_all = 0; m_err = 0; m_addr = '0; m_data = '0;
`ifdef TIMEOUT_EN
      idle_cnt = 0;
`endif
   endtask

   task automatic model_step(input logic en, input logic [15:0] a, input logic [7:0] d);
      wr_t cand[$];
      bit  prefix;
      int  done;
      m_wr = 0; m_er = 0; m_err = 0;
      if (!en) begin
`ifdef TIMEOUT_EN
         if (hist.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
               m_err = 1; hist.delete(); idle_cnt = 0;
            end
         end else begin
            idle_cnt = 0;
         end
`endif
         return;
      end
`ifdef TIMEOUT_EN
      idle_cnt = 0;
`endif
      if (d == 8'hF0) begin
         hist.delete();
         return;
      end
      cand = hist;
      cand.push_back(mk(a, d));
      prefix = 0;
      done   = -1;
      for (int p = 0; p < 4; p++) begin
         int r;
         r = match_pat(p, cand);
         if (r == 2) done = p;
         else if (r == 1) prefix = 1;
      end
      if (done >= 0) begin
         hist.delete();
         if (done == 1) begin m_wr = 1; m_addr = a; m_data = d; end
         if (done == 2) begin m_er = 1; m_all = 1; m_addr = A1; end
         if (done == 3) begin m_er = 1; m_all = 0; m_addr = a; end
      end else if (prefix) begin
         hist = cand;
      end else begin
         if (hist.size() != 0) m_err = 1;
         hist.delete();
         if (a == A1 && d == 8'hAA) hist.push_back(mk(a, d));
      end
   endtask

   function automatic logic [29:0] dut_vec();
      return {readEnable, busy, writeEnable, eraseEnable, erase_all, seq_error, op_addr, op_data};
   endfunction

   function automatic logic [29:0] exp_vec();
      logic idle;
      idle = (hist.size() == 0);
      return {idle, !idle, m_wr, m_er, m_all, m_err, m_addr, m_data};
   endfunction

   task automatic bus_cycle(input logic en, input logic [15:0] a, input logic [7:0] d);
      EN = en; address = a; data = d;
      @(posedge clk);
      #1;
      model_step(en, a, d);
      EN = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; EN = 1'b0; address = '0; data = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dut_vec() !== {1'b1, 29'd0}) begin
         failures++; $display("FAIL reset_state: got %h expected %h", dut_vec(), {1'b1, 29'd0});
      end
      #3 reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL after_reset_release: got %h expected %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_program();
      wr_t s[4];
      s = '{mk(A1, 8'hAA), mk(A2, 8'h55), mk(A1, 8'h20), mk(16'h0123, 8'h3C)};
      for (int i = 0; i < 4; i++) begin
         bus_cycle(1'b1, s[i].a, s[i].d);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL program_step%0d: got %h expected %h", i, dut_vec(), exp_vec());
         end
         checks++;
         if (i < 3 && busy !== 1'b1) begin
            failures++; $display("FAIL program_busy%0d: got %b expected 1", i, busy);
         end
      end
      checks++;
      if ({writeEnable, eraseEnable, readEnable, op_addr, op_data} !== {3'b101, 16'h0123, 8'h3C}) begin
         failures++;
         $display("FAIL program_strobe: got we=%b ee=%b re=%b addr=%h data=%h expected we=1 ee=0 re=1 addr=0123 data=3c",
                  writeEnable, eraseEnable, readEnable, op_addr, op_data);
      end
      bus_cycle(1'b0, '0, '0);
      checks++;
      if (writeEnable !== 1'b0) begin
         failures++; $display("FAIL program_pulse_width: got %b expected 0", writeEnable);
      end
   endtask

   task automatic test_erase();
      wr_t s[6];
      for (int k = 0; k < 2; k++) begin
         s = '{mk(A1, 8'hAA), mk(A2, 8'h55), mk(A1, 8'h80), mk(A1, 8'hAA), mk(A2, 8'h55),
               (k == 0) ? mk(A1, 8'h10) : mk(16'h4000, 8'h30)};
         for (int i = 0; i < 6; i++) begin
            bus_cycle(1'b1, s[i].a, s[i].d);
            checks++;
            if (dut_vec() !== exp_vec()) begin
               failures++; $display("FAIL erase%0d_step%0d: got %h expected %h", k, i, dut_vec(), exp_vec());
            end
         end
         checks++;
         if ({eraseEnable, writeEnable, erase_all, op_addr} !== {2'b10, (k == 0), (k == 0) ? A1 : 16'h4000}) begin
            failures++;
            $display("FAIL erase%0d_strobe: got ee=%b we=%b all=%b addr=%h expected ee=1 we=0 all=%0d addr=%h",
                     k, eraseEnable, writeEnable, erase_all, op_addr, (k == 0), (k == 0) ? A1 : 16'h4000);
         end
      end
   endtask

   task automatic test_error_resync();
      wr_t s[5];
      int  errs;
      bus_cycle(1'b1, A1, 8'hAA);
      bus_cycle(1'b1, A2, 8'h54);
      checks++;
      if ({seq_error, busy, readEnable} !== 3'b101) begin
         failures++; $display("FAIL error_abort: got err=%b busy=%b re=%b expected err=1 busy=0 re=1",
                              seq_error, busy, readEnable);
      end
      s = '{mk(A1, 8'hAA), mk(A1, 8'hAA), mk(A2, 8'h55), mk(A1, 8'h20), mk(16'h0001, 8'hFF)};
      errs = 0;
      for (int i = 0; i < 5; i++) begin
         bus_cycle(1'b1, s[i].a, s[i].d);
         errs += int'(seq_error);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL resync_step%0d: got %h expected %h", i, dut_vec(), exp_vec());
         end
      end
      checks++;
      if (errs != 1 || writeEnable !== 1'b1 || op_addr !== 16'h0001) begin
         failures++; $display("FAIL resync_result: got errors=%0d we=%b addr=%h expected errors=1 we=1 addr=0001",
                              errs, writeEnable, op_addr);
      end
   endtask

   task automatic test_reset_cmd();
      bus_cycle(1'b1, A1, 8'hAA);
      bus_cycle(1'b1, A2, 8'h55);
      bus_cycle(1'b1, 16'h1234, 8'hF0);
      checks++;
      if ({readEnable, busy, seq_error, writeEnable, eraseEnable} !== 5'b10000) begin
         failures++; $display("FAIL reset_cmd: got re/busy/err/we/ee=%b expected 10000",
                              {readEnable, busy, seq_error, writeEnable, eraseEnable});
      end
   endtask

   task automatic test_async_reset();
      bus_cycle(1'b1, A1, 8'hAA);
      bus_cycle(1'b1, A2, 8'h55);
      #2 reset = 1'b0;
      #1;
      model_reset();
      checks++;
      if (dut_vec() !== {1'b1, 29'd0}) begin
         failures++; $display("FAIL async_reset: got %h expected %h", dut_vec(), {1'b1, 29'd0});
      end
      @(negedge clk);
      #2 reset = 1'b1;
      bus_cycle(1'b1, A1, 8'h20);
      bus_cycle(1'b1, 16'h0010, 8'h11);
      checks++;
      if (writeEnable !== 1'b0 || dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL async_reset_followup: got %h expected %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_timeout();
      bus_cycle(1'b1, A1, 8'hAA);
`ifdef TIMEOUT_EN
      for (int i = 0; i < TMO; i++) begin
         bus_cycle(1'b0, '0, '0);
         checks++;
         if (seq_error !== (i == TMO - 1) || busy !== (i != TMO - 1)) begin
            failures++; $display("FAIL timeout_idle%0d: got err=%b busy=%b expected err=%0d busy=%0d",
                                 i, seq_error, busy, (i == TMO - 1), (i != TMO - 1));
         end
      end
`else
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 1000; i++) begin
            bus_cycle(1'b0, '0, '0);
            if (seq_error !== 1'b0 || busy !== 1'b1) bad++;
         end
         checks++;
         if (bad != 0) begin
            failures++; $display("FAIL no_timeout_wait: got %0d bad cycles expected 0", bad);
         end
         bus_cycle(1'b1, A2, 8'h55);
         bus_cycle(1'b1, A1, 8'h20);
         bus_cycle(1'b1, 16'h0042, 8'h5A);
         checks++;
         if (writeEnable !== 1'b1 || op_addr !== 16'h0042 || op_data !== 8'h5A) begin
            failures++; $display("FAIL no_timeout_complete: got we=%b addr=%h data=%h expected we=1 addr=0042 data=5a",
                                 writeEnable, op_addr, op_data);
         end
      end
`endif
      checks++;
      if (dut_vec() !== exp_vec()) begin
         failures++; $display("FAIL timeout_model: got %h expected %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      wr_t s[10];
      s = '{mk(A1, 8'hAA), mk(A2, 8'h55), mk(A1, 8'h20), mk(16'h0100, 8'hA5),
            mk(A1, 8'hAA), mk(A2, 8'h55), mk(A1, 8'h80), mk(A1, 8'hAA), mk(A2, 8'h55),
            mk(16'h7777, 8'h30)};
      for (int i = 0; i < 10; i++) begin
         bus_cycle(1'b1, s[i].a, s[i].d);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL b2b_step%0d: got %h expected %h", i, dut_vec(), exp_vec());
         end
         if (i == 4) begin
            checks++;
            if (busy !== 1'b1 || seq_error !== 1'b0) begin
               failures++; $display("FAIL b2b_accept: got busy=%b err=%b expected busy=1 err=0", busy, seq_error);
            end
         end
      end
      checks++;
      if ({eraseEnable, erase_all, op_addr, op_data} !== {2'b10, 16'h7777, 8'hA5}) begin
         failures++; $display("FAIL b2b_erase: got ee=%b all=%b addr=%h data=%h expected ee=1 all=0 addr=7777 data=a5",
                              eraseEnable, erase_all, op_addr, op_data);
      end
   endtask

   task automatic test_random();
      wr_t s[$];
      int  kind;
      for (int n = 0; n < 120; n++) begin
         s.delete();
         kind = $urandom_range(0, 4);
         s.push_back(mk(A1, 8'hAA));
         s.push_back(mk(A2, 8'h55));
         case (kind)
            0: s.push_back(mk(A1, 8'h00));
            1: begin s.push_back(mk(A1, 8'h20)); s.push_back(mk(16'($urandom), 8'($urandom))); end
            2, 3: begin
               s.push_back(mk(A1, 8'h80)); s.push_back(mk(A1, 8'hAA)); s.push_back(mk(A2, 8'h55));
               s.push_back((kind == 2) ? mk(A1, 8'h10) : mk(16'($urandom), 8'h30));
            end
            default: s.push_back(mk(16'($urandom), 8'($urandom)));
         endcase
         if ($urandom_range(0, 3) == 0) begin
            logic [7:0] dv;
            case ($urandom_range(0, 4))
               0: dv = 8'hAA; 1: dv = 8'h55; 2: dv = 8'h30; 3: dv = 8'hF0;
               default: dv = 8'($urandom);
            endcase
            s[$urandom_range(0, s.size() - 1)] = mk(($urandom_range(0, 1) == 0) ? A1 : 16'($urandom), dv);
         end
         foreach (s[i]) begin
            repeat ($urandom_range(0, 2)) begin
               bus_cycle(1'b0, 16'($urandom), 8'($urandom));
               checks++;
               if (dut_vec() !== exp_vec()) begin
                  failures++; $display("FAIL random_idle%0d: got %h expected %h", n, dut_vec(), exp_vec());
               end
            end
            bus_cycle(1'b1, s[i].a, s[i].d);
            checks++;
            if (dut_vec() !== exp_vec()) begin
               failures++; $display("FAIL random_seq%0d_w%0d: got %h expected %h", n, i, dut_vec(), exp_vec());
            end
         end
      end
   endtask

   initial begin
      init_patterns();
      test_reset();
      test_program();
      test_erase();
      test_error_resync();
      test_reset_cmd();
      test_async_reset();
      test_timeout();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
